// File: rtl/frec_divider_prog_if.sv
// Control/status bundle for the programmable clock-enable divider.
// master drives run/load controls; slave (the divider) returns the strobe, square wave and status.
interface frec_divider_prog_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             tick;
    logic             sq_out;
    logic [WIDTH-1:0] cur_div;
    logic             pending;
    logic             err;

    modport master (
        output en,
        output div_in,
        output div_load,
        input  tick,
        input  sq_out,
        input  cur_div,
        input  pending,
        input  err
    );

    modport slave (
        input  en,
        input  div_in,
        input  div_load,
        output tick,
        output sq_out,
        output cur_div,
        output pending,
        output err
    );
endinterface

// File: rtl/frec_divider_prog.sv
// Programmable divide-by-N clock-enable generator: one-cycle tick plus near-50% square wave,
// with a runtime-loadable ratio that only takes effect at a period boundary.
module frec_divider_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 1000
) (
    input  logic                clk,
    input  logic                rst,
    frec_divider_prog_if.slave  bus
);
    localparam logic [WIDTH-1:0] DEF_N   = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_CNT = WIDTH'(DEFAULT_DIV - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    if (DEFAULT_DIV < 2 || longint'(DEFAULT_DIV) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_default
        $error("frec_divider_prog: DEFAULT_DIV out of range [2, 2^WIDTH-1]");
    end

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] ratio;
    logic [WIDTH-1:0] pend_div;
    logic             pend_valid;
    logic             strobe;
    logic             sq;
    logic             err_pulse;

    logic             wrap;
    logic             apply;
    logic             load_ok;
    logic             load_bad;
    logic [WIDTH-1:0] ratio_next;
    logic [WIDTH-1:0] cnt_next;

    // A pending ratio is adopted either at a wrap or on any idle edge; idle keeps
    // the counter primed one short of N so the first enabled edge wraps at once.
    always_comb begin
        wrap       = (cnt == (ratio - ONE));
        apply      = pend_valid && (!bus.en || wrap);
        load_ok    = bus.div_load && (bus.div_in >= TWO);
        load_bad   = bus.div_load && (bus.div_in < TWO);
        ratio_next = apply ? pend_div : ratio;
        if (!bus.en) begin
            cnt_next = ratio_next - ONE;
        end else if (wrap) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= DEF_CNT;
            ratio      <= DEF_N;
            pend_div   <= DEF_N;
            pend_valid <= 1'b0;
            strobe     <= 1'b0;
            sq         <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            ratio     <= ratio_next;
            strobe    <= bus.en && wrap;
            sq        <= bus.en && (cnt_next < (ratio_next >> 1));
            err_pulse <= load_bad;
            // A load on the applying edge is kept for the following boundary.
            if (load_ok) begin
                pend_div   <= bus.div_in;
                pend_valid <= 1'b1;
            end else if (apply) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign bus.tick    = strobe;
    assign bus.sq_out  = sq;
    assign bus.cur_div = ratio;
    assign bus.pending = pend_valid;
    assign bus.err     = err_pulse;
endmodule

// File: tb/tb_frec_divider_prog.sv
// Self-checking bench for frec_divider_prog (WIDTH=8, DEFAULT_DIV=4): vector table,
// directed corner sequences and randomized traffic against a period/phase reference model.
module tb_frec_divider_prog;
    localparam int W   = 8;
    localparam int DEF = 4;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    frec_divider_prog_if #(.WIDTH(W)) bus ();

    frec_divider_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: "running" flag, phase within the current period, active and pending ratio.
    int m_run, m_phase, m_n, m_pn, m_pv, m_err;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic l, input int d);
        int  old_n;
        bit  boundary;
        if (!r) begin
            m_run = 0; m_phase = 0; m_n = DEF; m_pn = DEF; m_pv = 0; m_err = 0;
        end else begin
            old_n    = m_n;
            boundary = !e || (m_run == 0) || (m_phase == old_n - 1);
            m_err    = (l && d < 2) ? 1 : 0;
            if (e) m_phase = ((m_run == 0) || (m_phase == old_n - 1)) ? 0 : m_phase + 1;
            if (boundary && m_pv != 0) begin
                m_n  = m_pn;
                m_pv = 0;
            end
            m_run = e ? 1 : 0;
            if (l && d >= 2) begin
                m_pn = d;
                m_pv = 1;
            end
        end
    endtask

    task automatic compare_model();
        check("model_tick", 32'(bus.tick), (m_run != 0 && m_phase == 0) ? 1 : 0);
        check("model_sq", 32'(bus.sq_out), (m_run != 0 && m_phase < m_n / 2) ? 1 : 0);
        check("model_cur_div", 32'(bus.cur_div), 32'(m_n));
        check("model_pending", 32'(bus.pending), 32'(m_pv));
        check("model_err", 32'(bus.err), 32'(m_err));
    endtask

    task automatic step(input logic r, input logic e, input logic l, input int d);
        rst          = r;
        bus.en       = e;
        bus.div_load = l;
        bus.div_in   = W'(d);
        @(posedge clk);
        model_edge(r, e, l, d);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic r, e, l;
        int   d;
        logic x_tick, x_sq;
        int   x_cur;
        logic x_pend, x_err;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int t0, t1, nticks, sq_hi, max_cnt, idx;
        logic [5:0] pat6;
        logic [9:0] pat10;

        m_run = 0; m_phase = 0; m_n = DEF; m_pn = DEF; m_pv = 0; m_err = 0;
        rst = 1'b0; bus.en = 1'b0; bus.div_load = 1'b0; bus.div_in = '0;

        // Basic run (1100 pattern) followed by illegal loads of 0 and 1 while running.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 4, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 4, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 4, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 4, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 4, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 4, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1, 4, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 4, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 4, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 4, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1, 4, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 4, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 4, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 4, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].r, vecs[i].e, vecs[i].l, vecs[i].d);
            check($sformatf("vec%0d_tick", i), 32'(bus.tick), 32'(vecs[i].x_tick));
            check($sformatf("vec%0d_sq", i), 32'(bus.sq_out), 32'(vecs[i].x_sq));
            check($sformatf("vec%0d_cur", i), 32'(bus.cur_div), 32'(vecs[i].x_cur));
            check($sformatf("vec%0d_pend", i), 32'(bus.pending), 32'(vecs[i].x_pend));
            check($sformatf("vec%0d_err", i), 32'(bus.err), 32'(vecs[i].x_err));
        end

        // Odd ratio with latest-wins load while idle.
        step(1, 0, 0, 0);
        check("idle_tick", 32'(bus.tick), 0);
        check("idle_sq", 32'(bus.sq_out), 0);
        step(1, 0, 1, 9);
        step(1, 0, 1, 5);
        check("lw_pending", 32'(bus.pending), 1);
        step(1, 0, 0, 0);
        check("lw_cur_div", 32'(bus.cur_div), 5);
        check("lw_pending_clr", 32'(bus.pending), 0);
        pat10 = 10'b1100011000;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 0);
            check($sformatf("odd_sq_%0d", i), 32'(bus.sq_out), 32'(pat10[9 - i]));
            check($sformatf("odd_tick_%0d", i), 32'(bus.tick), (i % 5 == 0) ? 1 : 0);
        end

        // Back to N=4, then change to 6 two cycles after a tick.
        step(1, 0, 1, 4);
        step(1, 0, 0, 0);
        check("n4_cur", 32'(bus.cur_div), 4);
        step(1, 1, 0, 0);
        check("mid_first_tick", 32'(bus.tick), 1);
        step(1, 1, 0, 0);
        step(1, 1, 1, 6);
        step(1, 1, 0, 0);
        check("mid_pending", 32'(bus.pending), 1);
        check("mid_cur_old", 32'(bus.cur_div), 4);
        check("mid_no_tick", 32'(bus.tick), 0);
        step(1, 1, 0, 0);
        check("mid_tick4", 32'(bus.tick), 1);
        check("mid_cur_new", 32'(bus.cur_div), 6);
        check("mid_pend_clr", 32'(bus.pending), 0);
        pat6 = 6'b110001;
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0, 0);
            check($sformatf("n6_sq_%0d", i), 32'(bus.sq_out), 32'(pat6[5 - i]));
            check($sformatf("n6_tick_%0d", i), 32'(bus.tick), (i == 5) ? 1 : 0);
        end

        // Enable drop mid-period, re-enable, then reset during a pending load.
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        check("drop_tick", 32'(bus.tick), 0);
        check("drop_sq", 32'(bus.sq_out), 0);
        step(1, 1, 0, 0);
        check("reen_tick", 32'(bus.tick), 1);
        step(1, 1, 1, 9);
        check("rst_pre_pending", 32'(bus.pending), 1);
        step(0, 1, 1, 9);
        check("rst_cur", 32'(bus.cur_div), 4);
        check("rst_pending", 32'(bus.pending), 0);
        check("rst_tick", 32'(bus.tick), 0);
        check("rst_sq", 32'(bus.sq_out), 0);
        check("rst_err", 32'(bus.err), 0);

        // Maximum ratio.
        step(1, 0, 1, 255);
        step(1, 0, 0, 0);
        check("max_cur", 32'(bus.cur_div), 255);
        t0 = -1; t1 = -1; nticks = 0; sq_hi = 0; max_cnt = 0;
        for (int c = 0; c < 600 && nticks < 2; c++) begin
            step(1, 1, 0, 0);
            if (int'(dut.cnt) > max_cnt) max_cnt = int'(dut.cnt);
            if (bus.tick) begin
                if (nticks == 0) t0 = c; else t1 = c;
                nticks++;
            end
            if (nticks == 1 && bus.sq_out) sq_hi++;
        end
        check("max_ticks_seen", 32'(nticks), 2);
        check("max_period", 32'(t1 - t0), 255);
        check("max_sq_high", 32'(sq_hi), 127);
        check("max_cnt_bound", 32'(max_cnt <= 254), 1);

        // Randomized traffic against the model.
        step(0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            idx = int'($urandom_range(0, 99));
            step(idx != 0, idx > 8, $urandom_range(0, 9) == 0, int'($urandom_range(0, 12)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frec_divider_prog.md
# frec_divider_prog

Programmable, fully synchronous clock-enable generator. It is the parametrised successor to the fixed ripple-flop divider that feeds the servo PWM module. It produces two outputs from a single clock: a one-cycle `tick` strobe and a near-50 % `sq_out` square wave. The divide ratio is runtime-loadable and takes effect glitch-free at a period boundary. Output is a clock-enable, not a derived clock; downstream PWM logic stays on `clk`.

## Interface
- `WIDTH`, default 16: divisor and counter width.
- `DEFAULT_DIV`, default 1000: divide ratio after reset. Legal range is [2, 2^WIDTH−1]; elaboration fails otherwise.

- `clk`, input, 1: system clock. Only clock in the block.
- `rst`, input, 1: reset. Synchronous, active-low; sampled on the rising edge of `clk`.
- `en`, input, 1: run enable.
- `div_in`, input, WIDTH: new divide ratio.
- `div_load`, input, 1: one-cycle load strobe for `div_in`.
- `tick`, output, 1: one-cycle strobe, once per period.
- `sq_out`, output, 1: square wave, high for the first floor(N/2) cycles of each period.
- `cur_div`, output, WIDTH: divide ratio N currently in effect.
- `pending`, output, 1: a loaded ratio is waiting for the next boundary.
- `err`, output, 1: one-cycle pulse when an illegal ratio (0 or 1) is loaded.

## Operation
- **Internal state**
  - `cnt` (WIDTH bits).
  - `cur_div` (active ratio N).
  - `pend_div`, `pend_valid` (drives `pending`).
- **Reset** (`rst`=0 at an edge):
  - `cnt` = DEFAULT_DIV−1, `cur_div` = DEFAULT_DIV.
  - `pend_valid`=0, `tick`=0, `sq_out`=0, `err`=0.
  - Reset dominates every other input, including when asserted mid-period or mid-load.
- **Idle** (`en`=0):
  - `cnt` is held primed at `cur_div`−1; `tick`=0, `sq_out`=0.
  - If `pend_valid`=1: at the next edge, `cur_div`←`pend_div`, `cnt`←`pend_div`−1, and `pend_valid` clears.
- **Run** (`en`=1), at each edge:
  - If `cnt`==`cur_div`−1 (wrap):
    - `cnt`←0, `tick`←1.
    - If `pend_valid`: `cur_div`←`pend_div` and `pend_valid`←0.
  - Otherwise: `cnt`←`cnt`+1, `tick`←0.
  - `sq_out`←(`cnt_next` < (N_next >> 1)), where N_next is the ratio that applies after this edge.
- **Load**:
  - `div_load`=1 with `div_in` ≥ 2: `pend_div`←`div_in`, `pend_valid`←1.
  - A later load before the boundary overwrites the earlier one (latest wins).
  - `div_load`=1 with `div_in` < 2: `err`←1 for one cycle. `pend_div`, `pend_valid` and `cur_div` are unchanged.
- **Load on the wrap edge**: the load is captured into pending and applied at the following wrap. The wrap on that same edge uses the old pending value, if one existed.
- **Arithmetic**
  - Compares are unsigned, WIDTH-bit.
  - The `cnt`+1 increment never overflows, because `cnt` < N ≤ 2^WIDTH−1.
  - For odd N, `sq_out` is low for one extra cycle.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- First `tick` after `en` rises: `en` is sampled high at edge k, so `tick`=1 and `sq_out`=1 in the cycle after edge k. This is one cycle of latency.
- Steady state: `tick` period is exactly N cycles. The `sq_out` rising edge coincides with `tick`.
- Ratio change:
  - The new N governs the period that starts with the `tick` at which it is applied.
  - No period ever has a length other than the old N or the new N.
- `en` falling at edge k: `tick`=0 and `sq_out`=0 from the cycle after k. The partial period is discarded.
- `err` is high in the cycle after the illegal load edge.
- `pending` is high from the cycle after the load edge until the cycle after the applying edge.

## Test plan
All scenarios use WIDTH=8, DEFAULT_DIV=4.

1. **Basic run**: release reset, then `en`=1 held. First `tick` appears one cycle after `en` is sampled, then every 4 cycles. `sq_out` pattern is 1100 repeating, aligned to `tick`. `cur_div`=4.
2. **Odd ratio, latest-wins load**: with `en`=0, load 9, then load 5 on the next edge. `pending` is high. After one idle edge, `cur_div`=5 and `pending`=0. Set `en`=1: `tick` period is 5, `sq_out` pattern is 11000.
3. **Mid-period change**: running N=4, load 6 two cycles after a `tick`. The current period completes at 4 cycles. `pending` clears and `cur_div`=6 in the cycle of the next `tick`. Subsequent periods are 6 cycles with `sq_out` 111000.
4. **Illegal loads**: load 0, then 1, while running N=4. `err` pulses one cycle after each load. `cur_div`, `pending` and the 4-cycle `tick` spacing are unaffected.
5. **Enable drop and reset**:
   - Drop `en` mid-period: `tick` and `sq_out` are 0 from the next cycle. Re-enable: `tick` returns one cycle after `en` is sampled.
   - Assert `rst`=0 for one edge while N=6 is active and a load is pending: all outputs return to reset values, and `cur_div` returns to 4.
6. **Maximum ratio**: load 255. Verify a 255-cycle `tick` period and that `sq_out` is high for 127 cycles. Check that `cnt` never exceeds 254.
